// File: rtl/multicycle_exec_ctrl_if.sv
// multicycle_exec_ctrl_if: shared instruction/data memory port (req/ready handshake)
interface multicycle_exec_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_is_instr;
  logic mem_ready;
  modport master(output mem_req, mem_we, mem_is_instr, input mem_ready);
  modport slave(input mem_req, mem_we, mem_is_instr, output mem_ready);
endinterface

// File: rtl/multicycle_exec_ctrl.sv
// multicycle_exec_ctrl: multi-cycle control FSM; ports clk/reset, run, instr, zero, bus (memory port), exec-unit controls, strobes, pc_sel, illegal, state, retired
module multicycle_exec_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [31:0]          instr,
  input  logic                 zero,
  multicycle_exec_ctrl_if.master bus,
  output logic [2:0]           ALUop,
  output logic                 ExtOp,
  output logic                 ALUSrc,
  output logic                 RegDst,
  output logic                 RegWr,
  output logic                 MemtoReg,
  output logic                 ir_wr,
  output logic                 aluout_wr,
  output logic                 pc_wr,
  output logic [1:0]           pc_sel,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic inc, req, we, is_instr;
  logic [5:0] op, fn;
  logic is_r, is_imm, is_lw, is_sw, is_br, is_j;
  logic [2:0] r_op;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign is_r = op == 6'h00 && (fn[5:2] == 4'b1000 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A || fn == 6'h2B);
  assign is_imm = op == 6'h08 || op == 6'h09;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2B;
  assign is_br = op == 6'h04 || op == 6'h05;
  assign is_j = op == 6'h02;
  assign r_op = fn[5:1] == 5'b10000 ? 3'd0 : fn[5:1] == 5'b10001 ? 3'd1 :
                fn == 6'h24 ? 3'd2 : fn == 6'h25 ? 3'd3 : fn == 6'h2A ? 3'd4 : 3'd5;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pend_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    inc = 1'b0;
    ALUop = 3'd0;
    ExtOp = 1'b0;
    ALUSrc = 1'b0;
    RegDst = 1'b0;
    RegWr = 1'b0;
    MemtoReg = 1'b0;
    req = 1'b0;
    we = 1'b0;
    is_instr = 1'b0;
    ir_wr = 1'b0;
    aluout_wr = 1'b0;
    pc_wr = 1'b0;
    pc_sel = 2'b00;
    illegal = 1'b0;
    case (state_q)
      FETCH: begin
        // a request once raised stays up until served, even if run drops
        req = run | pend_q;
        is_instr = req;
        ir_wr = req & bus.mem_ready;
        pend_d = req & ~bus.mem_ready;
        state_d = ir_wr ? DECODE : FETCH;
      end
      DECODE: begin
        illegal = ~(is_r | is_imm | is_lw | is_sw | is_br | is_j);
        pc_wr = illegal;
        state_d = illegal ? FETCH : is_br ? BRANCH : is_j ? JUMP : EXEC;
      end
      EXEC: begin
        aluout_wr = 1'b1;
        ALUSrc = ~is_r;
        ExtOp = ~is_r;
        RegDst = is_r;
        ALUop = is_r ? r_op : 3'd0;
        state_d = (is_lw | is_sw) ? MEM : WB;
      end
      MEM: begin
        req = 1'b1;
        we = ~is_lw;
        pc_wr = ~is_lw & bus.mem_ready;
        inc = pc_wr;
        state_d = bus.mem_ready ? (is_lw ? WB : FETCH) : MEM;
      end
      WB: begin
        RegWr = 1'b1;
        pc_wr = 1'b1;
        inc = 1'b1;
        RegDst = is_r;
        MemtoReg = is_lw;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUop = 3'd1;
        ExtOp = 1'b1;
        pc_wr = 1'b1;
        inc = 1'b1;
        pc_sel = {1'b0, zero ^ (op == 6'h05)};
        state_d = FETCH;
      end
      JUMP: begin
        pc_wr = 1'b1;
        pc_sel = 2'b10;
        inc = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    retired_d = retired_q + CNT_W'(inc);
  end
  assign bus.mem_req = req;
  assign bus.mem_we = we;
  assign bus.mem_is_instr = is_instr;
  assign state = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_exec_ctrl.sv
// tb_multicycle_exec_ctrl: directed self-checking bench for multicycle_exec_ctrl
module tb_multicycle_exec_ctrl;
  logic clk = 1'b0;
  logic reset, run, zero;
  logic [31:0] instr;
  logic [2:0] ALUop, state;
  logic ExtOp, ALUSrc, RegDst, RegWr, MemtoReg, ir_wr, aluout_wr, pc_wr, illegal;
  logic [1:0] pc_sel;
  logic [31:0] retired;
  int n_chk = 0;
  int n_fail = 0;
  int ret_exp = 0;
  multicycle_exec_ctrl_if m();
  multicycle_exec_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero), .bus(m),
    .ALUop(ALUop), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .RegWr(RegWr),
    .MemtoReg(MemtoReg), .ir_wr(ir_wr), .aluout_wr(aluout_wr), .pc_wr(pc_wr),
    .pc_sel(pc_sel), .illegal(illegal), .state(state), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [31:0] iv);
    instr = iv;
    run = 1'b1;
    m.mem_ready = 1'b1;
    #1;
    chk("fetch_state", 32'(state), 0);
    chk("fetch_req", 32'(m.mem_req), 1);
    chk("fetch_instr", 32'(m.mem_is_instr), 1);
    chk("fetch_we", 32'(m.mem_we), 0);
    chk("fetch_irwr", 32'(ir_wr), 1);
    step;
    chk("dec_state", 32'(state), 1);
  endtask
  task automatic run_r(input logic [5:0] fn, input logic [2:0] eop);
    fetch_decode({6'h00, 5'd1, 5'd2, 5'd4, 5'd0, fn});
    chk("r_dec_illegal", 32'(illegal), 0);
    step;
    chk("r_exec_state", 32'(state), 2);
    chk("r_aluop", 32'(ALUop), 32'(eop));
    chk("r_alusrc", 32'(ALUSrc), 0);
    chk("r_regdst", 32'(RegDst), 1);
    chk("r_aluout_wr", 32'(aluout_wr), 1);
    step;
    chk("r_wb_state", 32'(state), 4);
    chk("r_wb_regwr", 32'(RegWr), 1);
    chk("r_wb_regdst", 32'(RegDst), 1);
    chk("r_wb_memtoreg", 32'(MemtoReg), 0);
    chk("r_wb_pcwr", 32'(pc_wr), 1);
    chk("r_wb_pcsel", 32'(pc_sel), 0);
    step;
    ret_exp++;
    chk("r_done_state", 32'(state), 0);
    chk("r_retired", retired, 32'(ret_exp));
  endtask
  task automatic run_br(input logic [31:0] iv, input logic z, input logic [1:0] esel);
    zero = z;
    fetch_decode(iv);
    step;
    chk("br_state", 32'(state), 5);
    chk("br_aluop", 32'(ALUop), 1);
    chk("br_extop", 32'(ExtOp), 1);
    chk("br_alusrc", 32'(ALUSrc), 0);
    chk("br_pcwr", 32'(pc_wr), 1);
    chk("br_pcsel", 32'(pc_sel), 32'(esel));
    step;
    ret_exp++;
    chk("br_done_state", 32'(state), 0);
    chk("br_retired", retired, 32'(ret_exp));
  endtask
  task automatic run_ill(input logic [31:0] iv);
    fetch_decode(iv);
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_pcwr", 32'(pc_wr), 1);
    chk("ill_pcsel", 32'(pc_sel), 0);
    step;
    chk("ill_state", 32'(state), 0);
    chk("ill_pulse_gone", 32'(illegal), 0);
    chk("ill_retired", retired, 32'(ret_exp));
  endtask
  logic [5:0] fns [7] = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
  logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  initial begin
    reset = 1'b1;
    run = 1'b0;
    zero = 1'b0;
    instr = 32'h0;
    m.mem_ready = 1'b1;
    step;
    step;
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    reset = 1'b0;
    step;
    step;
    chk("idle_state", 32'(state), 0);
    chk("idle_req", 32'(m.mem_req), 0);
    chk("idle_irwr", 32'(ir_wr), 0);
    run_r(6'h20, 3'd0);
    for (int i = 0; i < 7; i++) run_r(fns[i], ops[i]);
    // lw with two wait cycles in MEM
    fetch_decode(32'h8C220004);
    step;
    chk("lw_exec_state", 32'(state), 2);
    chk("lw_alusrc", 32'(ALUSrc), 1);
    chk("lw_extop", 32'(ExtOp), 1);
    chk("lw_aluop", 32'(ALUop), 0);
    m.mem_ready = 1'b0;
    step;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m.mem_ready = 1'b1;
      #1;
      chk("lw_mem_state", 32'(state), 3);
      chk("lw_mem_req", 32'(m.mem_req), 1);
      chk("lw_mem_instr", 32'(m.mem_is_instr), 0);
      chk("lw_mem_we", 32'(m.mem_we), 0);
      chk("lw_mem_pcwr", 32'(pc_wr), 0);
      step;
    end
    chk("lw_wb_state", 32'(state), 4);
    chk("lw_memtoreg", 32'(MemtoReg), 1);
    chk("lw_regdst", 32'(RegDst), 0);
    chk("lw_regwr", 32'(RegWr), 1);
    step;
    ret_exp++;
    chk("lw_retired", retired, 32'(ret_exp));
    // sw
    fetch_decode(32'hAC220004);
    step;
    chk("sw_exec_regwr", 32'(RegWr), 0);
    step;
    chk("sw_mem_state", 32'(state), 3);
    chk("sw_mem_we", 32'(m.mem_we), 1);
    chk("sw_mem_req", 32'(m.mem_req), 1);
    chk("sw_regwr", 32'(RegWr), 0);
    chk("sw_pcwr", 32'(pc_wr), 1);
    chk("sw_pcsel", 32'(pc_sel), 0);
    step;
    ret_exp++;
    chk("sw_state", 32'(state), 0);
    chk("sw_retired", retired, 32'(ret_exp));
    run_br(32'h10220003, 1'b1, 2'b01);
    run_br(32'h10220003, 1'b0, 2'b00);
    run_br(32'h14220003, 1'b0, 2'b01);
    run_br(32'h14220003, 1'b1, 2'b00);
    // j
    fetch_decode(32'h08000010);
    step;
    chk("j_state", 32'(state), 6);
    chk("j_pcsel", 32'(pc_sel), 2);
    chk("j_pcwr", 32'(pc_wr), 1);
    step;
    ret_exp++;
    chk("j_retired", retired, 32'(ret_exp));
    run_ill(32'hFC000000);
    run_ill(32'h00000000);
    // fetch held while run drops, then instruction finishes and FETCH idles
    instr = 32'h08000010;
    m.mem_ready = 1'b0;
    #1;
    chk("hold_req0", 32'(m.mem_req), 1);
    chk("hold_irwr0", 32'(ir_wr), 0);
    step;
    run = 1'b0;
    #1;
    chk("hold_state", 32'(state), 0);
    chk("hold_req1", 32'(m.mem_req), 1);
    step;
    m.mem_ready = 1'b1;
    #1;
    chk("hold_irwr", 32'(ir_wr), 1);
    step;
    chk("hold_dec", 32'(state), 1);
    step;
    chk("hold_jump", 32'(state), 6);
    step;
    ret_exp++;
    chk("hold_idle_state", 32'(state), 0);
    chk("hold_idle_req", 32'(m.mem_req), 0);
    chk("hold_retired", retired, 32'(ret_exp));
    step;
    chk("hold_still_idle", 32'(state), 0);
    // reset in MEM with request pending
    fetch_decode(32'h8C220004);
    step;
    m.mem_ready = 1'b0;
    step;
    chk("rmem_state", 32'(state), 3);
    chk("rmem_req", 32'(m.mem_req), 1);
    reset = 1'b1;
    run = 1'b0;
    m.mem_ready = 1'b1;
    step;
    chk("rmem_after_state", 32'(state), 0);
    chk("rmem_after_req", 32'(m.mem_req), 0);
    chk("rmem_after_retired", retired, 0);
    reset = 1'b0;
    step;
    chk("rmem_idle_state", 32'(state), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
